bsg_test_addr_gen: RTL
======================

# bsg_test_addr_gen

Request generator for the DRAM bandwidth test bench. It emits a programmable-length stream of channel addresses using a valid/yumi handshake. It sits directly upstream of the credit-limited test master, which accepts each address and forwards it to the DRAM model. The address pattern is selected at start: sequential, strided, or pseudo-random. The block counts accepted requests and raises a done flag once the programmed total has been consumed.

## Interface
- `channel_addr_width_p`, default "inv": width of the channel address; must be 1..32.
- `num_request_p`, default "inv": total requests per run; must be ≥1.
- `stride_p`, default 1: address increment used in strided mode.
- `lfsr_seed_p`, default 32'h1: nonzero 32-bit LFSR seed (random mode only).
- `clk_i  input  1`: clock.
- `reset_n_i  input  1`: reset, asynchronous, active-low.
- `start_i  input  1`: begin a run; sampled only in IDLE or DONE.
- `mode_i  input  2`: pattern select, sampled with `start_i`: 0 = sequential, 1 = strided, 2 = random, 3 = sequential.
- `base_addr_i  input  channel_addr_width_p`: first address, sampled with `start_i`.
- `v_o  output  1`: address valid.
- `ch_addr_o  output  channel_addr_width_p`: current address.
- `yumi_i  input  1`: consumer accepts `ch_addr_o` this cycle; legal only while `v_o`=1.
- `done_o  output  1`: run complete.
- `issued_o  output  BSG_WIDTH(num_request_p)`: requests accepted so far in this run.

## Operation
- FSM states:
  - IDLE: `v_o`=0, `done_o`=0.
  - RUN: `v_o`=1.
  - DONE: `v_o`=0, `done_o`=1.
- Transitions:
  - IDLE or DONE, with `start_i`=1 → RUN. On this edge: latch the mode, set addr=`base_addr_i`, clear `issued_o`, load the LFSR with `lfsr_seed_p`.
  - RUN, on `yumi_i` with `issued_o`==num_request_p-1 → DONE.
  - `start_i` is ignored in RUN.
- Next-address rule, applied on each `yumi_i` in RUN; all arithmetic is modulo 2^channel_addr_width_p, so wrap-around is silent.
  - Sequential: addr+1.
  - Strided: addr+`stride_p`, truncated to the address width.
  - Random: step a 32-bit Galois LFSR (taps 32,22,2,1; mask 32'h80200003); addr = `base_addr_i` + lfsr[channel_addr_width_p-1:0].
- `issued_o` increments by 1 on each `yumi_i`. Maximum value is num_request_p, held in DONE until the next start.
- `yumi_i` while `v_o`=0 is a protocol error. It is ignored; there is no state change.
- Reset (any time, including mid-run): state=IDLE, `v_o`=0, `done_o`=0, `ch_addr_o`=0, `issued_o`=0, LFSR=`lfsr_seed_p`. Outputs clear asynchronously on assertion.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Start latency: `start_i` high at edge N → `v_o`=1 with `ch_addr_o`=`base_addr_i` during cycle N+1.
- Hold rule: `ch_addr_o` and `v_o` are stable while `v_o`=1 and `yumi_i`=0.
- Throughput: one address per cycle. With `yumi_i` held high, new addresses are presented back-to-back with no bubble.
- Last request: `yumi_i` at edge M on the final request → in cycle M+1, `v_o`=0, `done_o`=1, and `issued_o`=num_request_p.
- `start_i` in the same cycle as the final `yumi_i` is ignored, because the state is still RUN at that edge.
- num_request_p=1: a single `yumi_i` goes directly RUN → DONE.

## Configuration
- `BSG_TEST_ADDR_GEN_RANDOM_EN` defined: the LFSR and random mode are compiled in.
- Undefined: no LFSR is instantiated, and mode 2 behaves exactly as sequential.
- The `lfsr_seed_p` parameter remains in the interface either way; it is unused when the macro is undefined.

## Test plan
- Reset mid-run: W=8, N=16, sequential, base=0x10. Assert `reset_n_i`=0 after 5 accepts → outputs go to zero asynchronously. Release reset, then start → `ch_addr_o`=0x10 and `issued_o`=0.
- Sequential wrap: W=4, N=4, base=0xE, `yumi_i` tied high → addresses 0xE, 0xF, 0x0, 0x1 on consecutive cycles. `done_o`=1 in the cycle after the 4th accept, with `issued_o`=4.
- Strided with backpressure: W=8, stride=3, N=3, base=0, `yumi_i` toggled 1,0,0,1,1 → addresses 0,3,3,3,6. `ch_addr_o` is held during stall cycles.
- Random mode (macro on): seed=1, base=0x00, W=8 → the 2nd address equals the low byte of the LFSR after one step from 1 (0x02). Rerunning with the same start reproduces the same sequence.
- Random mode (macro off): mode=2, base=0x20 → addresses 0x20, 0x21, 0x22.
- Restart and ignore: `start_i` during RUN has no effect. `start_i` in DONE → new run begins the next cycle, `done_o` drops to 0, and `issued_o` clears to 0.

Source files
------------

// File: rtl/bsg_test_addr_gen.sv
// Address request generator for DRAM bandwidth tests (valid/yumi handshake).
// Define BSG_TEST_ADDR_GEN_RANDOM_EN to compile in the LFSR random mode.
module bsg_test_addr_gen #(
    parameter int          channel_addr_width_p = 8,
    parameter int          num_request_p        = 16,
    parameter int          stride_p             = 1,
    parameter logic [31:0] lfsr_seed_p          = 32'h1
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            start_i,
    input  logic [1:0]                      mode_i,
    input  logic [channel_addr_width_p-1:0] base_addr_i,
    output logic                            v_o,
    output logic [channel_addr_width_p-1:0] ch_addr_o,
    input  logic                            yumi_i,
    output logic                            done_o,
    output logic [$clog2(num_request_p+1)-1:0] issued_o
);

    localparam int aw_lp = channel_addr_width_p;
    localparam int iw_lp = $clog2(num_request_p+1);

    localparam logic [1:0] idle_s = 2'd0;
    localparam logic [1:0] run_s  = 2'd1;
    localparam logic [1:0] done_s = 2'd2;

    localparam logic [aw_lp-1:0] stride_lp = aw_lp'(stride_p);
    localparam logic [iw_lp-1:0] last_lp   = iw_lp'(num_request_p - 1);

    logic [1:0]       state_q, state_d;
    logic [aw_lp-1:0] addr_q, addr_d, addr_nxt;
    logic [iw_lp-1:0] issued_q, issued_d;
    logic             strided_q, strided_d;

`ifdef BSG_TEST_ADDR_GEN_RANDOM_EN
    logic             random_q, random_d;
    logic [aw_lp-1:0] base_q, base_d;
    logic [31:0]      lfsr_q, lfsr_d, lfsr_nxt;

    // Left-shifting Galois LFSR, feedback taken from bit 31
    assign lfsr_nxt = {lfsr_q[30:0], 1'b0} ^ (lfsr_q[31] ? 32'h80200003 : 32'h0);

    always_comb begin
        if (random_q)
            addr_nxt = base_q + lfsr_nxt[aw_lp-1:0];
        else if (strided_q)
            addr_nxt = addr_q + stride_lp;
        else
            addr_nxt = addr_q + aw_lp'(1);
    end
`else
    always_comb begin
        if (strided_q)
            addr_nxt = addr_q + stride_lp;
        else
            addr_nxt = addr_q + aw_lp'(1);
    end
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        issued_d  = issued_q;
        strided_d = strided_q;
`ifdef BSG_TEST_ADDR_GEN_RANDOM_EN
        random_d  = random_q;
        base_d    = base_q;
        lfsr_d    = lfsr_q;
`endif
        case (state_q)
            idle_s, done_s: begin
                if (start_i) begin
                    state_d   = run_s;
                    addr_d    = base_addr_i;
                    issued_d  = '0;
                    strided_d = (mode_i == 2'd1);
`ifdef BSG_TEST_ADDR_GEN_RANDOM_EN
                    random_d  = (mode_i == 2'd2);
                    base_d    = base_addr_i;
                    lfsr_d    = lfsr_seed_p;
`endif
                end
            end
            run_s: begin
                if (yumi_i) begin
                    addr_d   = addr_nxt;
                    issued_d = issued_q + iw_lp'(1);
`ifdef BSG_TEST_ADDR_GEN_RANDOM_EN
                    if (random_q)
                        lfsr_d = lfsr_nxt;
`endif
                    if (issued_q == last_lp)
                        state_d = done_s;
                end
            end
            default: state_d = idle_s;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= idle_s;
            addr_q    <= '0;
            issued_q  <= '0;
            strided_q <= 1'b0;
`ifdef BSG_TEST_ADDR_GEN_RANDOM_EN
            random_q  <= 1'b0;
            base_q    <= '0;
            lfsr_q    <= lfsr_seed_p;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            issued_q  <= issued_d;
            strided_q <= strided_d;
`ifdef BSG_TEST_ADDR_GEN_RANDOM_EN
            random_q  <= random_d;
            base_q    <= base_d;
            lfsr_q    <= lfsr_d;
`endif
        end
    end

    assign v_o       = (state_q == run_s);
    assign done_o    = (state_q == done_s);
    assign ch_addr_o = addr_q;
    assign issued_o  = issued_q;

endmodule
